frame_tx_sequencer: RTL and testbench
=====================================

Name: frame_tx_sequencer

Overview:
- Sequences one camera frame through the UART image wrapper (Avalon side), then collects the returned prediction bytes.
- Pulls RGB pixels from the SRAM read stream and serializes each into R, G, B bytes on the wrapper's byte/ready handshake.
- Stores the fixed-length prediction result in a local buffer that the overlay logic reads back.
- Flags completion, or a timeout if the host stops answering.

Parameters:
- H_PIXELS, 640, pixels per line
- V_LINES, 480, lines per frame
- N_PRED, 120, prediction bytes per frame (15 boxes x 8 points)
- TIMEOUT_CYCLES, 50000000, maximum idle cycles between prediction bytes

Ports:
- avm_clk  in  1  clock
- avm_rst_n  in  1  asynchronous active-low reset
- i_trigger  in  1  start one frame (level sampled, acted on in IDLE only)
- o_busy  out  1  high from trigger acceptance until DONE exit
- i_pix_valid  in  1  pixel available on i_pix_data
- i_pix_data  in  24  {R[23:16], G[15:8], B[7:0]}
- o_pix_ready  out  1  one-cycle pulse: pixel consumed this cycle
- o_start_send  out  1  one-cycle pulse to the wrapper starting a transfer
- o_byte_data  out  8  current byte to transmit
- i_byte_ready  in  1  wrapper consumed o_byte_data this cycle
- i_pred_data  in  8  prediction byte
- i_pred_valid  in  1  i_pred_data valid (single-cycle strobe)
- i_res_raddr  in  7  result buffer read address
- o_res_rdata  out  8  result byte at i_res_raddr (combinational read)
- o_pred_cnt  out  7  prediction bytes stored this frame
- o_frame_done  out  1  one-cycle pulse on DONE entry
- o_error  out  1  sticky timeout flag; cleared on next trigger acceptance

Behaviour:
- Reset values (async, avm_rst_n low): state=IDLE; all counters 0; o_busy, o_pix_ready, o_start_send, o_frame_done, o_error = 0; o_byte_data=0; o_pred_cnt=0. The result buffer is not cleared.
- IDLE: if i_trigger, go to KICK. Set o_busy=1, clear o_error, set o_pred_cnt=0, set h=v=0.
- KICK (1 cycle): o_start_send=1, then go to FETCH.
- FETCH: wait for i_pix_valid.
  - When i_pix_valid: o_pix_ready=1 that same cycle and latch the pixel.
  - Next cycle: o_byte_data=R, color=0, go to SEND.
- SEND: o_byte_data stays stable until i_byte_ready.
  - On i_byte_ready with color<2: color++ and o_byte_data updates to G or B on the next edge.
  - On i_byte_ready with color==2: advance h (wrap at H_PIXELS-1 to 0, then v++).
  - If h==H_PIXELS-1 and v==V_LINES-1: go to WAIT_PRED and clear the timeout counter. Otherwise go to FETCH.
- Total bytes sent = 3*H_PIXELS*V_LINES. i_byte_ready outside SEND is ignored.
- WAIT_PRED:
  - On i_pred_valid: write the byte to buffer[o_pred_cnt], o_pred_cnt++, clear the timeout counter.
  - When the written byte is number N_PRED (o_pred_cnt reaches N_PRED): go to DONE.
  - Without i_pred_valid: the timeout counter increments. At TIMEOUT_CYCLES-1, set o_error=1 and go to DONE, keeping the partial o_pred_cnt.
- i_pred_valid in any state other than WAIT_PRED is ignored; no buffer write.
- DONE (1 cycle): o_frame_done=1, o_busy=0 on exit, go to IDLE. A trigger held high restarts the frame on the following cycle through IDLE.
- i_trigger while busy: ignored.
- Buffer write and read at the same address in the same cycle: o_res_rdata returns the old value; the new value is visible the next cycle.
- Counter widths: h 10b, v 10b, color 2b, timeout counter ceil(log2(TIMEOUT_CYCLES)) bits. No counter overflows past its terminal value.
- Reset mid-frame: immediate return to IDLE, no o_frame_done pulse. Buffer contents are undefined for partial frames.

Test Plan (H_PIXELS=4, V_LINES=2, N_PRED=4, TIMEOUT_CYCLES=16 unless noted):
- Trigger, pixels 0x112233..0x889900, i_byte_ready every 3rd cycle -> o_start_send exactly once; 24 bytes in order 11,22,33,...; WAIT_PRED entered after byte 24.
- After the send, pred bytes A0,A1,A2,A3 with gaps of 5 cycles -> o_res_rdata[0..3]=A0..A3, o_pred_cnt=4, single o_frame_done, o_error=0.
- Only 2 pred bytes, then silence -> o_error=1 exactly 16 cycles after the 2nd byte, o_pred_cnt=2, o_frame_done pulses.
- i_pix_valid withheld 20 cycles in FETCH, i_trigger re-pulsed mid-frame -> o_byte_data stable, no new o_start_send, byte order unchanged.
- i_pred_valid during SEND, and i_byte_ready during WAIT_PRED -> buffer untouched, counts unaffected.
- avm_rst_n low during the 10th byte, then a new trigger -> all outputs at reset values; the new frame starts at pixel 0, byte R.

Source files
------------

// File: rtl/frame_tx_sequencer.sv
// ---------------------------------------------------------------------------
// frame_tx_sequencer
//
// Walks one camera frame through the UART image wrapper on the Avalon clock
// domain, then gathers the prediction bytes the host sends back.
//
// Flow per frame:
//   IDLE -> KICK (pulse o_start_send) -> { FETCH -> SEND x3 bytes } per pixel
//        -> WAIT_PRED (collect N_PRED bytes or time out) -> DONE -> IDLE
//
// Ports:
//   avm_clk, avm_rst_n   clock, asynchronous active-low reset
//   i_trigger            start a frame (sampled in IDLE only)
//   o_busy               high from trigger acceptance until DONE exits
//   i_pix_valid/i_pix_data/o_pix_ready
//                        SRAM pixel stream; o_pix_ready is a one-cycle
//                        consume strobe
//   o_start_send         one-cycle pulse telling the wrapper a transfer begins
//   o_byte_data/i_byte_ready
//                        byte handshake to the wrapper (R, G, B per pixel)
//   i_pred_data/i_pred_valid
//                        prediction bytes returned by the host
//   i_res_raddr/o_res_rdata
//                        combinational read port into the result buffer
//   o_pred_cnt           prediction bytes stored in the current frame
//   o_frame_done         one-cycle pulse when DONE is entered
//   o_error              sticky timeout flag, cleared on the next trigger
// ---------------------------------------------------------------------------
module frame_tx_sequencer #(
  parameter int H_PIXELS       = 640,
  parameter int V_LINES        = 480,
  parameter int N_PRED         = 120,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic        avm_clk,
  input  logic        avm_rst_n,
  input  logic        i_trigger,
  output logic        o_busy,
  input  logic        i_pix_valid,
  input  logic [23:0] i_pix_data,
  output logic        o_pix_ready,
  output logic        o_start_send,
  output logic [7:0]  o_byte_data,
  input  logic        i_byte_ready,
  input  logic [7:0]  i_pred_data,
  input  logic        i_pred_valid,
  input  logic [6:0]  i_res_raddr,
  output logic [7:0]  o_res_rdata,
  output logic [6:0]  o_pred_cnt,
  output logic        o_frame_done,
  output logic        o_error
);

  localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int BUF_AW = (N_PRED > 1) ? $clog2(N_PRED) : 1;

  // Terminal values pre-sized to the counters they are compared against.
  localparam logic [9:0]      H_LAST     = 10'(H_PIXELS - 1);
  localparam logic [9:0]      V_LAST     = 10'(V_LINES - 1);
  localparam logic [6:0]      PRED_LAST  = 7'(N_PRED - 1);
  localparam logic [6:0]      PRED_DEPTH = 7'(N_PRED);
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KICK,
    ST_FETCH,
    ST_SEND,
    ST_WAIT_PRED,
    ST_DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [9:0]      h_cnt;
  logic [9:0]      v_cnt;
  logic [1:0]      color;
  logic [TO_W-1:0] timeout_cnt;
  logic [15:0]     pix_gb;

  logic [7:0] res_buf [N_PRED];

  // Single-cycle control strobes decoded by the next-state logic.
  logic accept_trig;
  logic take_pix;
  logic byte_adv;
  logic pix_done;
  logic frame_sent;
  logic pred_take;
  logic timeout_hit;

  // State register.
  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the strobes that steer the datapath registers.
  always_comb begin
    state_next   = state;
    accept_trig  = 1'b0;
    take_pix     = 1'b0;
    byte_adv     = 1'b0;
    pix_done     = 1'b0;
    frame_sent   = 1'b0;
    pred_take    = 1'b0;
    timeout_hit  = 1'b0;
    o_busy       = (state != ST_IDLE);
    o_start_send = (state == ST_KICK);
    o_frame_done = (state == ST_DONE);

    unique case (state)
      ST_IDLE: begin
        if (i_trigger) begin
          accept_trig = 1'b1;
          state_next  = ST_KICK;
        end
      end

      ST_KICK: begin
        state_next = ST_FETCH;
      end

      ST_FETCH: begin
        if (i_pix_valid) begin
          take_pix   = 1'b1;
          state_next = ST_SEND;
        end
      end

      ST_SEND: begin
        if (i_byte_ready) begin
          if (color == 2'd2) begin
            // Blue byte consumed: this pixel is finished. The last pixel of
            // the frame is recognised from the pre-advance h/v position.
            pix_done = 1'b1;
            if ((h_cnt == H_LAST) && (v_cnt == V_LAST)) begin
              frame_sent = 1'b1;
              state_next = ST_WAIT_PRED;
            end else begin
              state_next = ST_FETCH;
            end
          end else begin
            byte_adv = 1'b1;
          end
        end
      end

      ST_WAIT_PRED: begin
        if (i_pred_valid) begin
          pred_take = 1'b1;
          if (o_pred_cnt == PRED_LAST) begin
            state_next = ST_DONE;
          end
        end else if (timeout_cnt == TO_LAST) begin
          timeout_hit = 1'b1;
          state_next  = ST_DONE;
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    o_pix_ready = take_pix;
  end

  // Pixel latch and outgoing byte. Red goes straight to the output on the
  // consume edge; green and blue are held until the wrapper asks for them.
  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      pix_gb      <= 16'h0000;
      o_byte_data <= 8'h00;
      color       <= 2'd0;
    end else if (take_pix) begin
      pix_gb      <= i_pix_data[15:0];
      o_byte_data <= i_pix_data[23:16];
      color       <= 2'd0;
    end else if (byte_adv) begin
      color       <= color + 2'd1;
      o_byte_data <= (color == 2'd0) ? pix_gb[15:8] : pix_gb[7:0];
    end
  end

  // Raster position. Both counters fold back to zero after the last pixel
  // so neither ever runs past its terminal value.
  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      h_cnt <= 10'd0;
      v_cnt <= 10'd0;
    end else if (accept_trig) begin
      h_cnt <= 10'd0;
      v_cnt <= 10'd0;
    end else if (pix_done) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= 10'd0;
        v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Idle-cycle counter between prediction bytes. It saturates implicitly
  // because reaching TO_LAST leaves WAIT_PRED on the same edge.
  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      timeout_cnt <= '0;
    end else if (frame_sent || pred_take) begin
      timeout_cnt <= '0;
    end else if ((state == ST_WAIT_PRED) && !timeout_hit) begin
      timeout_cnt <= timeout_cnt + 1'b1;
    end
  end

  // Prediction count and the sticky timeout flag, both restarted when a new
  // frame is accepted. A timeout keeps the partial count for inspection.
  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      o_pred_cnt <= 7'd0;
      o_error    <= 1'b0;
    end else begin
      if (accept_trig) begin
        o_pred_cnt <= 7'd0;
        o_error    <= 1'b0;
      end else begin
        if (pred_take) begin
          o_pred_cnt <= o_pred_cnt + 7'd1;
        end
        if (timeout_hit) begin
          o_error <= 1'b1;
        end
      end
    end
  end

  // Result buffer: plain registers without reset so the overlay logic can
  // still read the last frame's result after a reset.
  always_ff @(posedge avm_clk) begin
    if (pred_take) begin
      res_buf[o_pred_cnt[BUF_AW-1:0]] <= i_pred_data;
    end
  end

  // Combinational read; a write to the same address shows up one cycle
  // later because the register has not been updated yet.
  assign o_res_rdata = (i_res_raddr < PRED_DEPTH) ? res_buf[i_res_raddr[BUF_AW-1:0]] : 8'h00;

endmodule

// File: tb/tb_frame_tx_sequencer.sv
// ---------------------------------------------------------------------------
// tb_frame_tx_sequencer
//
// Self-checking bench for frame_tx_sequencer with a 4x2 frame, 4 prediction
// bytes and a 16-cycle timeout. The reference is a byte queue built from the
// pixel table (R, G, B per pixel, raster order) and a shadow copy of the
// result buffer. Inputs change on the falling edge; outputs are sampled 1 ns
// later, well away from the rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_frame_tx_sequencer;

  localparam int H           = 4;
  localparam int V           = 2;
  localparam int NP          = 4;
  localparam int TO          = 16;
  localparam int NPIX        = H * V;
  localparam int NBYTES      = 3 * NPIX;
  localparam int SEND_BUDGET = 3000;

  logic        avm_clk = 1'b0;
  logic        avm_rst_n;
  logic        i_trigger;
  logic        o_busy;
  logic        i_pix_valid;
  logic [23:0] i_pix_data;
  logic        o_pix_ready;
  logic        o_start_send;
  logic [7:0]  o_byte_data;
  logic        i_byte_ready;
  logic [7:0]  i_pred_data;
  logic        i_pred_valid;
  logic [6:0]  i_res_raddr;
  logic [7:0]  o_res_rdata;
  logic [6:0]  o_pred_cnt;
  logic        o_frame_done;
  logic        o_error;

  int n_tests = 0;
  int n_fail  = 0;

  logic [23:0] cur_pix  [NPIX];
  logic [7:0]  cur_pred [NP];
  logic [7:0]  model_buf [NP];
  bit          model_ok  [NP];
  logic [7:0]  last_byte;

  frame_tx_sequencer #(
    .H_PIXELS      (H),
    .V_LINES       (V),
    .N_PRED        (NP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .avm_clk     (avm_clk),
    .avm_rst_n   (avm_rst_n),
    .i_trigger   (i_trigger),
    .o_busy      (o_busy),
    .i_pix_valid (i_pix_valid),
    .i_pix_data  (i_pix_data),
    .o_pix_ready (o_pix_ready),
    .o_start_send(o_start_send),
    .o_byte_data (o_byte_data),
    .i_byte_ready(i_byte_ready),
    .i_pred_data (i_pred_data),
    .i_pred_valid(i_pred_valid),
    .i_res_raddr (i_res_raddr),
    .o_res_rdata (o_res_rdata),
    .o_pred_cnt  (o_pred_cnt),
    .o_frame_done(o_frame_done),
    .o_error     (o_error)
  );

  always #5 avm_clk = ~avm_clk;

  // Hard stop in case something above hangs despite the per-phase bounds.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic rand_frame();
    for (int p = 0; p < NPIX; p++) cur_pix[p] = 24'($urandom);
    for (int k = 0; k < NP; k++) cur_pred[k] = 8'($urandom);
  endtask

  task automatic forget_buffer();
    for (int k = 0; k < NP; k++) model_ok[k] = 1'b0;
  endtask

  // Trigger a frame (unless the trigger is already being held) and check the
  // KICK cycle that follows.
  task automatic start_frame(input bit already);
    if (!already) begin
      @(negedge avm_clk); i_trigger = 1'b1; #1;
      n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_busy: got %b expected 0", o_busy); end
    end
    @(negedge avm_clk); i_trigger = 1'b0; #1;
    n_tests++; if (o_start_send !== 1'b1) begin n_fail++; $display("[TB] FAIL kick_start: got %b expected 1", o_start_send); end
    n_tests++; if (o_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL kick_busy: got %b expected 1", o_busy); end
    n_tests++; if (o_error !== 1'b0) begin n_fail++; $display("[TB] FAIL kick_error_clear: got %b expected 0", o_error); end
    n_tests++; if (o_pred_cnt !== 7'd0) begin n_fail++; $display("[TB] FAIL kick_pred_cnt: got %0d expected 0", o_pred_cnt); end
  endtask

  // Feed cur_pix and consume bytes. ready_period 0 means random readiness.
  // stall_at withholds i_pix_valid 20 cycles before that pixel while pulsing
  // i_trigger. abort_at stops once that many bytes have been handed over.
  task automatic run_send(input int ready_period, input int stall_at,
                          input bit pred_noise, input int abort_at);
    logic [7:0] exp_q[$];
    int pend, pix_idx, got, cyc, stall_left, extra_start;
    bit stalling;
    exp_q = {};
    foreach (cur_pix[p]) begin
      exp_q.push_back(cur_pix[p][23:16]);
      exp_q.push_back(cur_pix[p][15:8]);
      exp_q.push_back(cur_pix[p][7:0]);
    end
    pend = 0; pix_idx = 0; got = 0; cyc = 0; stall_left = 20; extra_start = 0;
    while ((got < NBYTES) && !((abort_at >= 0) && (got == abort_at)) && (cyc < SEND_BUDGET)) begin
      @(negedge avm_clk);
      cyc++;
      stalling     = (pend == 0) && (pix_idx == stall_at) && (stall_left > 0);
      i_pix_valid  = (pend == 0) && (pix_idx < NPIX) && !stalling;
      i_pix_data   = (pix_idx < NPIX) ? cur_pix[pix_idx] : 24'h000000;
      if (ready_period > 0) i_byte_ready = (pend > 0) && ((cyc % ready_period) == 0);
      else                  i_byte_ready = (pend > 0) && ($urandom_range(0, 1) == 1);
      i_trigger    = stalling;
      i_pred_valid = pred_noise && ($urandom_range(0, 1) == 1);
      i_pred_data  = 8'($urandom);
      #1;
      if (o_start_send === 1'b1) extra_start++;
      if (stalling) begin
        stall_left--;
        n_tests++; if (o_pix_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_pix_ready: got %b expected 0", o_pix_ready); end
        n_tests++; if (o_byte_data !== exp_q[got-1]) begin n_fail++; $display("[TB] FAIL stall_byte: got %h expected %h", o_byte_data, exp_q[got-1]); end
      end
      if (pend > 0) begin
        n_tests++; if (o_byte_data !== exp_q[got]) begin n_fail++; $display("[TB] FAIL byte[%0d]: got %h expected %h", got, o_byte_data, exp_q[got]); end
        if (i_byte_ready) begin got++; pend--; end
      end else if (o_pix_ready === 1'b1) begin
        pix_idx++;
        pend = 3;
      end
      if (pred_noise) begin
        n_tests++; if (o_pred_cnt !== 7'd0) begin n_fail++; $display("[TB] FAIL send_pred_cnt: got %0d expected 0", o_pred_cnt); end
      end
    end
    if (abort_at < 0) begin
      n_tests++; if (got != NBYTES) begin n_fail++; $display("[TB] FAIL send_count: got %0d bytes expected %0d within %0d cycles", got, NBYTES, SEND_BUDGET); end
      n_tests++; if (extra_start != 0) begin n_fail++; $display("[TB] FAIL start_send_once: got %0d extra pulses expected 0", extra_start); end
      last_byte = exp_q[NBYTES-1];
    end else begin
      n_tests++; if (got != abort_at) begin n_fail++; $display("[TB] FAIL abort_count: got %0d bytes expected %0d", got, abort_at); end
    end
  endtask

  // Return n prediction bytes from cur_pred. gap < 0 gives random gaps.
  // With noise set, i_byte_ready toggles randomly while waiting.
  task automatic run_pred(input int n, input int gap, input bit noise, input bit hold_trig);
    int g;
    for (int k = 0; k < n; k++) begin
      g = (gap < 0) ? $urandom_range(0, 6) : gap;
      repeat (g) begin
        @(negedge avm_clk);
        i_pred_valid = 1'b0; i_trigger = 1'b0;
        i_byte_ready = noise && ($urandom_range(0, 1) == 1);
        #1;
        n_tests++; if (o_frame_done !== 1'b0) begin n_fail++; $display("[TB] FAIL early_done: got %b expected 0", o_frame_done); end
        if (noise) begin
          n_tests++; if (o_byte_data !== last_byte) begin n_fail++; $display("[TB] FAIL wait_byte: got %h expected %h", o_byte_data, last_byte); end
        end
      end
      @(negedge avm_clk);
      i_pred_valid = 1'b1; i_pred_data = cur_pred[k]; i_res_raddr = 7'(k);
      i_byte_ready = noise && ($urandom_range(0, 1) == 1);
      i_trigger    = hold_trig && (k == n - 1);
      #1;
      if (model_ok[k]) begin
        n_tests++; if (o_res_rdata !== model_buf[k]) begin n_fail++; $display("[TB] FAIL rd_old[%0d]: got %h expected %h", k, o_res_rdata, model_buf[k]); end
      end
      model_buf[k] = cur_pred[k];
      model_ok[k]  = 1'b1;
      @(negedge avm_clk);
      i_pred_valid = 1'b0; i_byte_ready = 1'b0;
      #1;
      n_tests++; if (o_pred_cnt !== 7'(k + 1)) begin n_fail++; $display("[TB] FAIL pred_cnt: got %0d expected %0d", o_pred_cnt, k + 1); end
      n_tests++; if (o_res_rdata !== cur_pred[k]) begin n_fail++; $display("[TB] FAIL rd_new[%0d]: got %h expected %h", k, o_res_rdata, cur_pred[k]); end
      n_tests++; if (o_frame_done !== (k + 1 == NP)) begin n_fail++; $display("[TB] FAIL done_pulse: got %b expected %b", o_frame_done, (k + 1 == NP)); end
      if (k + 1 == NP) begin
        n_tests++; if (o_error !== 1'b0) begin n_fail++; $display("[TB] FAIL done_error: got %b expected 0", o_error); end
      end
    end
  endtask

  // Cycle after DONE: back in IDLE, pulse gone.
  task automatic finish_frame(input bit hold);
    @(negedge avm_clk);
    if (!hold) i_trigger = 1'b0;
    #1;
    n_tests++; if (o_frame_done !== 1'b0) begin n_fail++; $display("[TB] FAIL done_once: got %b expected 0", o_frame_done); end
    n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_after_done: got %b expected 0", o_busy); end
    n_tests++; if (o_start_send !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_start: got %b expected 0", o_start_send); end
  endtask

  task automatic check_buffer();
    for (int a = 0; a < NP; a++) begin
      @(negedge avm_clk);
      i_pred_valid = 1'b0; i_byte_ready = 1'b0; i_trigger = 1'b0; i_res_raddr = 7'(a);
      #1;
      if (model_ok[a]) begin
        n_tests++; if (o_res_rdata !== model_buf[a]) begin n_fail++; $display("[TB] FAIL buffer[%0d]: got %h expected %h", a, o_res_rdata, model_buf[a]); end
      end
    end
  endtask

  task automatic check_reset_outputs();
    n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_busy: got %b expected 0", o_busy); end
    n_tests++; if (o_pix_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_pix_ready: got %b expected 0", o_pix_ready); end
    n_tests++; if (o_start_send !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_start_send: got %b expected 0", o_start_send); end
    n_tests++; if (o_frame_done !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_frame_done: got %b expected 0", o_frame_done); end
    n_tests++; if (o_error !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_error: got %b expected 0", o_error); end
    n_tests++; if (o_byte_data !== 8'h00) begin n_fail++; $display("[TB] FAIL rst_byte_data: got %h expected 00", o_byte_data); end
    n_tests++; if (o_pred_cnt !== 7'd0) begin n_fail++; $display("[TB] FAIL rst_pred_cnt: got %0d expected 0", o_pred_cnt); end
  endtask

  task automatic test_reset();
    avm_rst_n = 1'b0; i_trigger = 1'b0; i_pix_valid = 1'b0; i_pix_data = 24'h0;
    i_byte_ready = 1'b0; i_pred_data = 8'h0; i_pred_valid = 1'b0; i_res_raddr = 7'd0;
    forget_buffer();
    #1;
    check_reset_outputs();
    repeat (3) @(negedge avm_clk);
    avm_rst_n = 1'b1;
    @(negedge avm_clk); #1;
    check_reset_outputs();
  endtask

  task automatic test_frame_basic();
    cur_pix  = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC,
                 24'hDDEEFF, 24'h102030, 24'h405060, 24'h889900};
    cur_pred = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    start_frame(1'b0);
    run_send(3, -1, 1'b0, -1);
    run_pred(NP, 4, 1'b0, 1'b0);
    finish_frame(1'b0);
    check_buffer();
  endtask

  task automatic test_timeout();
    rand_frame();
    start_frame(1'b0);
    run_send(0, -1, 1'b0, -1);
    run_pred(2, 3, 1'b1, 1'b0);
    // Sample j reflects the state after the (j-1)th edge following byte 2.
    for (int j = 2; j <= TO + 1; j++) begin
      @(negedge avm_clk);
      i_byte_ready = ($urandom_range(0, 1) == 1);
      #1;
      n_tests++; if (o_error !== (j == TO + 1)) begin n_fail++; $display("[TB] FAIL timeout_error@%0d: got %b expected %b", j - 1, o_error, (j == TO + 1)); end
      n_tests++; if (o_frame_done !== (j == TO + 1)) begin n_fail++; $display("[TB] FAIL timeout_done@%0d: got %b expected %b", j - 1, o_frame_done, (j == TO + 1)); end
    end
    n_tests++; if (o_pred_cnt !== 7'd2) begin n_fail++; $display("[TB] FAIL timeout_pred_cnt: got %0d expected 2", o_pred_cnt); end
    forget_buffer();
    i_byte_ready = 1'b0;
    finish_frame(1'b0);
    n_tests++; if (o_error !== 1'b1) begin n_fail++; $display("[TB] FAIL error_sticky: got %b expected 1", o_error); end
  endtask

  task automatic test_stall_retrigger();
    rand_frame();
    start_frame(1'b0);
    run_send(3, 3, 1'b0, -1);
    run_pred(NP, -1, 1'b0, 1'b0);
    finish_frame(1'b0);
    check_buffer();
  endtask

  task automatic test_ignored_strobes();
    rand_frame();
    start_frame(1'b0);
    run_send(0, -1, 1'b1, -1);
    check_buffer();
    n_tests++; if (o_pred_cnt !== 7'd0) begin n_fail++; $display("[TB] FAIL wait_pred_cnt: got %0d expected 0", o_pred_cnt); end
    run_pred(NP, -1, 1'b1, 1'b0);
    finish_frame(1'b0);
    check_buffer();
  endtask

  task automatic test_reset_midframe();
    rand_frame();
    start_frame(1'b0);
    run_send(3, -1, 1'b0, 9);
    @(negedge avm_clk);
    i_byte_ready = 1'b0; i_pix_valid = 1'b0;
    #2 avm_rst_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) begin
      @(negedge avm_clk); #1;
      n_tests++; if (o_frame_done !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_no_done: got %b expected 0", o_frame_done); end
    end
    @(negedge avm_clk);
    avm_rst_n = 1'b1;
    forget_buffer();
    rand_frame();
    start_frame(1'b0);
    run_send(2, -1, 1'b0, -1);
    run_pred(NP, -1, 1'b0, 1'b0);
    finish_frame(1'b0);
    check_buffer();
  endtask

  task automatic test_back_to_back();
    rand_frame();
    start_frame(1'b0);
    run_send(0, -1, 1'b0, -1);
    for (int f = 0; f < 3; f++) begin
      run_pred(NP, -1, 1'b0, 1'b1);
      finish_frame(1'b1);
      rand_frame();
      start_frame(1'b1);
      run_send(0, -1, 1'b0, -1);
    end
    run_pred(NP, -1, 1'b0, 1'b0);
    finish_frame(1'b0);
    check_buffer();
  endtask

  initial begin
    test_reset();
    test_frame_basic();
    test_timeout();
    test_stall_retrigger();
    test_ignored_strobes();
    test_reset_midframe();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
